// File: rtl/calc_pkg.sv
// Shared definitions for the calculator arithmetic unit.
// Op codes, FSM state encoding and default operand width.
package calc_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/calc_mul_seq.sv
// Sequential shift-add multiplier on unsigned magnitudes.
// One multiplier bit per cycle; fin marks the final step.
module calc_mul_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic [2*WIDTH-1:0] product_o,
  output logic               fin_o
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  logic [W2-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [W2-1:0]    acc_q;
  logic [W2-1:0]    acc_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;

  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) acc_d = acc_q + mcand_q;
  end

  // Product is exposed on the last step so the parent
  // captures it on the same edge the step completes.
  assign product_o = acc_d;
  assign fin_o     = busy_q && (cnt_q == '0);
  assign busy_o    = busy_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (go_i && !busy_q) begin
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= CW'(WIDTH - 1);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/calc_op_unit.sv
// Calculator arithmetic controller: add, subtract, multiply
// with overflow reporting and a sticky error flag.
module calc_op_unit
  import calc_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             clr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             v,
  output logic             err
);

  localparam int WX = WIDTH + 1;
  localparam int W2 = 2 * WIDTH;

  state_e           state_q;
  logic [WIDTH-1:0] x_q;
  logic [WX-1:0]    y_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] result_q;
  logic             v_q;
  logic             err_q;
  logic             busy_q;
  logic             done_q;

  logic [WX-1:0]    y_ext;
  logic [WX-1:0]    y_neg;
  logic [WX-1:0]    sum;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             mul_go;
  logic             mul_busy;
  logic             mul_fin;
  logic [W2-1:0]    mul_prod;
  logic [W2-1:0]    prod_s;
  logic [WIDTH:0]   prod_top;
  logic             mul_ovf;
  logic             neg;
  logic             ill;
  logic             is_mul;
  logic             ex_fin;
  logic [WIDTH-1:0] res_d;
  logic             v_d;

  assign y_ext = {b_in[WIDTH-1], b_in};
  // Negate in the extended width so -2^(W-1) stays exact.
  assign y_neg = ~y_ext + WX'(1);

  assign a_mag = a_in[WIDTH-1] ? (~a_in + WIDTH'(1)) : a_in;
  assign b_mag = b_in[WIDTH-1] ? (~b_in + WIDTH'(1)) : b_in;

  assign is_mul = (op_q == OP_MUL) && MUL_EN;
  assign ill    = (op_q == OP_ILL) || ((op_q == OP_MUL) && !MUL_EN);
  assign mul_go = (state_q == LOAD) && (op == OP_MUL) && MUL_EN && !mul_busy;

  calc_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .go_i     (mul_go),
    .a_i      (a_mag),
    .b_i      (b_mag),
    .busy_o   (mul_busy),
    .product_o(mul_prod),
    .fin_o    (mul_fin)
  );

  assign sum      = {x_q[WIDTH-1], x_q} + y_q;
  assign neg      = x_q[WIDTH-1] ^ y_q[WIDTH];
  assign prod_s   = neg ? (~mul_prod + W2'(1)) : mul_prod;
  assign prod_top = prod_s[W2-1:WIDTH-1];
  assign mul_ovf  = !((&prod_top) || (~|prod_top));

  always_comb begin
    ex_fin = 1'b1;
    res_d  = sum[WIDTH-1:0];
    v_d    = sum[WIDTH] ^ sum[WIDTH-1];
    if (ill) begin
      res_d = '0;
      v_d   = 1'b0;
    end else if (is_mul) begin
      ex_fin = mul_fin;
      res_d  = prod_s[WIDTH-1:0];
      v_d    = mul_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      op_q     <= OP_ADD;
      result_q <= '0;
      v_q      <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (clr) err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          x_q     <= a_in;
          y_q     <= (op == OP_SUB) ? y_neg : y_ext;
          op_q    <= op;
          state_q <= EXEC;
        end
        EXEC: begin
          if (ex_fin) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= res_d;
            v_q      <= v_d;
            if (v_d || ill) err_q <= 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign v      = v_q;
  assign err    = err_q;

endmodule

// File: tb/tb_calc_op_unit.sv
// Directed bench for calc_op_unit at WIDTH=8.
// Hand-computed vectors for latency, results and flags.
module tb_calc_op_unit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       clr;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       v;
  logic       err;

  int n_chk;
  int n_pass;
  int lat;
  int bc;

  calc_op_unit #(
    .WIDTH (8),
    .MUL_EN(1'b1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a_in  (a_in),
    .b_in  (b_in),
    .clr   (clr),
    .busy  (busy),
    .done  (done),
    .result(result),
    .v     (v),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue start at the next edge and wait for done.
  task automatic run(input logic [1:0] o, input logic [7:0] a,
                     input logic [7:0] b, input bit hold,
                     output int n, output int nb);
    op    = o;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    n     = 0;
    nb    = 0;
    do begin
      tick();
      n++;
      if (!hold) start = 1'b0;
      if (busy) nb++;
    end while (!done && n < 60);
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b0;
    start  = 1'b0;
    op     = 2'b00;
    a_in   = '0;
    b_in   = '0;
    clr    = 1'b0;
    repeat (3) tick();
    chk("reset_out", {busy, done, v, err, result}, 32'h0);
    rst = 1'b1;
    tick();

    run(2'b00, 8'd100, 8'd27, 0, lat, bc);
    chk("add1_lat", lat, 3);
    chk("add1_res", {v, err, result}, {2'b00, 8'h7F});

    run(2'b00, 8'd100, 8'd28, 0, lat, bc);
    chk("add2_res", {v, err, result}, {2'b11, 8'h80});
    repeat (3) tick();
    chk("add2_hold", {v, err, result}, {2'b11, 8'h80});
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_err", err, 0);

    run(2'b01, 8'd5, 8'h80, 0, lat, bc);
    chk("sub1_res", {v, result}, {1'b1, 8'h85});
    run(2'b01, 8'hFD, 8'd4, 0, lat, bc);
    chk("sub2_res", {v, result}, {1'b0, 8'hF9});
    clr = 1'b1;
    tick();
    clr = 1'b0;

    run(2'b10, 8'hF9, 8'd9, 0, lat, bc);
    chk("mul1_lat", lat, 10);
    chk("mul1_busy", bc, 9);
    chk("mul1_res", {v, err, result}, {2'b00, 8'hC1});
    run(2'b10, 8'd16, 8'd8, 0, lat, bc);
    chk("mul2_res", {v, result}, {1'b1, 8'h80});
    run(2'b10, 8'hF0, 8'd8, 0, lat, bc);
    chk("mul3_res", {v, result}, {1'b0, 8'h80});
    clr = 1'b1;
    tick();
    clr = 1'b0;

    run(2'b11, 8'd5, 8'd3, 0, lat, bc);
    chk("ill_lat", lat, 3);
    chk("ill_res", {v, err, result}, {2'b01, 8'h00});
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ill_clr", err, 0);

    op    = 2'b00;
    a_in  = 8'd100;
    b_in  = 8'd28;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("set_wins", {done, err}, 2'b11);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_later", err, 0);

    run(2'b10, 8'd3, 8'd5, 1, lat, bc);
    chk("hold_mul_lat", lat, 10);
    chk("hold_mul_res", result, 8'h0F);
    run(2'b00, 8'd1, 8'd2, 1, lat, bc);
    chk("b2b_lat1", lat, 3);
    chk("b2b_res1", result, 8'h03);
    run(2'b00, 8'd10, 8'd20, 1, lat, bc);
    chk("b2b_lat2", lat, 3);
    chk("b2b_res2", result, 8'h1E);
    start = 1'b0;
    tick();
    chk("b2b_idle", {busy, done}, 2'b00);

    run(2'b00, 8'd100, 8'd28, 0, lat, bc);
    op    = 2'b10;
    a_in  = 8'hF9;
    b_in  = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_mid", {busy, done, v, err, result}, 32'h0);
    rst = 1'b1;
    bc  = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) bc++;
    end
    chk("rst_no_done", bc, 0);
    run(2'b00, 8'd1, 8'd2, 0, lat, bc);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_res", {v, err, result}, {2'b00, 8'h03});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
